pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MA, WB). It generates the per-stage write enables and flushes that stall, bubble, flush or freeze the pipeline, covering three cases:
- load-use hazards that the EX/MA–MA/WB forwarding path cannot cover, because a load in EX/MA is never forwarded;
- taken branches and jumps resolved in EX;
- data-memory wait states.

It sits beside the forwarding unit and drives the pipeline register enables and the PC enable.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/ir_reg_use.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM states,
// control-vector encodings and the register-use match helper.
package pipe_pkg;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] LUI   = 6'h0F;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU2   = 2'd1,
    MWAIT = 2'd2
  } state_t;

  // Bit order: {PC_Wr, IF_ID_Wr, ID_EX_Wr, EX_MA_Wr, MA_WB_Wr, IF_ID_Flush, ID_EX_Flush}
  localparam logic [6:0] CTL_NORM   = 7'b11111_00;
  localparam logic [6:0] CTL_BUBBLE = 7'b00111_01;
  localparam logic [6:0] CTL_FLUSH  = 7'b11111_11;
  localparam logic [6:0] CTL_FREEZE = 7'b00000_00;
  localparam logic [6:0] CTL_RESET  = 7'b00000_11;

  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic       rd_rs,
                                     input logic       rd_rt,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (dst != 5'd0) && ((rd_rs && (rs == dst)) || (rd_rt && (rt == dst)));
  endfunction

endpackage

// File: rtl/ir_reg_use.sv
// Register-use decode of one MIPS instruction: destination register and
// which source fields are actually read.
module ir_reg_use
  import pipe_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  dst,
  output logic        reads_rs,
  output logic        reads_rt
);

  logic [5:0] op;
  logic       unused_bits;

  assign op          = ir[31:26];
  assign unused_bits = &{1'b0, ir[10:0]};

  always_comb begin
    dst = ir[20:16];
    if (op == RTYPE) begin
      dst = ir[15:11];
    end else if (op == JAL) begin
      dst = REG_RA;
    end
    reads_rs = !((op == J) || (op == JAL) || (op == LUI));
    reads_rt = (op == RTYPE) || (op == BEQ) || (op == BNE) || (op == SW);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencing for the 5-stage MIPS pipeline.
// Optional statistics counters are built only when HAZ_STAT_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IF_ID_IR,
  input  logic [31:0]      ID_EX_IR,
  input  logic [31:0]      EX_MA_IR,
  input  logic             ID_EX_RegWr,
  input  logic             ID_EX_MemtoReg,
  input  logic             EX_MA_RegWr,
  input  logic             EX_MA_MemtoReg,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             ID_EX_Wr,
  output logic             EX_MA_Wr,
  output logic             MA_WB_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             mem_err,
`ifdef HAZ_STAT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       state
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state_r, state_nx, ret_state, eff_state;
  logic [WC_W-1:0] wait_cnt;
  logic [6:0]      ctl;
  logic            mwait, lu_ex, lu_ma, bubble, br_cyc;

  logic [4:0] id_dst, ex_dst, ma_dst;
  logic       id_rs, id_rt, ex_rs, ex_rt, ma_rs, ma_rt;
  logic       unused_dec;

  ir_reg_use u_dec_id (.ir(IF_ID_IR), .dst(id_dst), .reads_rs(id_rs), .reads_rt(id_rt));
  ir_reg_use u_dec_ex (.ir(ID_EX_IR), .dst(ex_dst), .reads_rs(ex_rs), .reads_rt(ex_rt));
  ir_reg_use u_dec_ma (.ir(EX_MA_IR), .dst(ma_dst), .reads_rs(ma_rs), .reads_rt(ma_rt));

  assign unused_dec = &{1'b0, id_dst, ex_rs, ex_rt, ma_rs, ma_rt};

  // Loads are never forwarded from EX/MA, so a load in EX or MA feeding ID must stall.
  assign lu_ex = ID_EX_RegWr && ID_EX_MemtoReg &&
                 reg_match(ex_dst, id_rs, id_rt, IF_ID_IR[25:21], IF_ID_IR[20:16]);
  assign lu_ma = EX_MA_RegWr && EX_MA_MemtoReg &&
                 reg_match(ma_dst, id_rs, id_rt, IF_ID_IR[25:21], IF_ID_IR[20:16]);
  assign mwait = dmem_req && !dmem_ready;

  // While frozen, decisions resume from the state that was interrupted.
  assign eff_state = (state_r == MWAIT) ? ret_state : state_r;

  always_comb begin
    ctl      = CTL_NORM;
    state_nx = RUN;
    bubble   = 1'b0;
    br_cyc   = 1'b0;
    if (rst) begin
      ctl = CTL_RESET;
    end else if (mwait) begin
      ctl      = CTL_FREEZE;
      state_nx = MWAIT;
    end else if (ex_branch_taken) begin
      ctl    = CTL_FLUSH;
      br_cyc = 1'b1;
    end else if (eff_state == LU2) begin
      ctl    = CTL_BUBBLE;
      bubble = 1'b1;
    end else if (lu_ex) begin
      ctl      = CTL_BUBBLE;
      state_nx = LU2;
      bubble   = 1'b1;
    end else if (lu_ma) begin
      ctl    = CTL_BUBBLE;
      bubble = 1'b1;
    end
  end

  assign {PC_Wr, IF_ID_Wr, ID_EX_Wr, EX_MA_Wr, MA_WB_Wr, IF_ID_Flush, ID_EX_Flush} = ctl;
  assign state = state_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      ret_state <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (mwait) begin
        if (state_r != MWAIT) ret_state <= state_r;
        if (wait_cnt < WC_MAX) wait_cnt <= wait_cnt + WC_W'(1);
        if (wait_cnt >= WC_LAST) mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZ_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble || mwait) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_cyc)          flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of per-cycle vectors plus
// hand-written reset and memory-timeout sequences, checked through a queue.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] LW2   = 32'h8C22_0000; // lw  $2,0($1)
  localparam logic [31:0] LW5   = 32'h8C25_0000; // lw  $5,0($1)
  localparam logic [31:0] LW0   = 32'h8C20_0004; // lw  $0,4($1)
  localparam logic [31:0] ADD   = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] SUB   = 32'h00A7_3022; // sub $6,$5,$7
  localparam logic [31:0] ADD0  = 32'h0000_1820; // add $3,$0,$0
  localparam logic [31:0] JMP   = 32'h0800_0100; // j 0x100
  localparam logic [31:0] JMP2  = 32'h0842_0000; // j with rs/rt fields = 2
  localparam logic [31:0] LUI2  = 32'h3C42_0005; // lui with rs field = 2
  localparam logic [31:0] ADDI  = 32'h2082_0001; // addi $2,$4,1
  localparam logic [31:0] SW2   = 32'hAC22_0000; // sw  $2,0($1)
  localparam logic [31:0] JAL_I = 32'h0C00_0040; // jal
  localparam logic [31:0] JR31  = 32'h03E0_0008; // jr $31

  localparam logic [6:0] NORM = 7'b11111_00;
  localparam logic [6:0] BUB  = 7'b00111_01;
  localparam logic [6:0] FLS  = 7'b11111_11;
  localparam logic [6:0] FRZ  = 7'b00000_00;
  localparam logic [6:0] RSTV = 7'b00000_11;

  localparam logic [1:0] S_RUN = 2'd0, S_LU2 = 2'd1, S_MW = 2'd2;

  typedef struct {
    logic        rst;
    logic [31:0] if_ir, ex_ir, ma_ir;
    logic        ex_rw, ex_m2r, ma_rw, ma_m2r, br, req, rdy;
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic        err;
  } vec_t;

  typedef struct {
    logic [6:0] ctl;
    logic [1:0] st;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_IR, ID_EX_IR, EX_MA_IR;
  logic        ID_EX_RegWr, ID_EX_MemtoReg, EX_MA_RegWr, EX_MA_MemtoReg;
  logic        ex_branch_taken, dmem_req, dmem_ready;
  logic        PC_Wr, IF_ID_Wr, ID_EX_Wr, EX_MA_Wr, MA_WB_Wr, IF_ID_Flush, ID_EX_Flush;
  logic        mem_err;
  logic [1:0]  state;
`ifdef HAZ_STAT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_IR(IF_ID_IR), .ID_EX_IR(ID_EX_IR), .EX_MA_IR(EX_MA_IR),
    .ID_EX_RegWr(ID_EX_RegWr), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .EX_MA_RegWr(EX_MA_RegWr), .EX_MA_MemtoReg(EX_MA_MemtoReg),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EX_Wr(ID_EX_Wr), .EX_MA_Wr(EX_MA_Wr),
    .MA_WB_Wr(MA_WB_Wr), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .mem_err(mem_err),
`ifdef HAZ_STAT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [31:0] i_if,
                              input logic [31:0] i_ex, input logic e_rw, input logic e_m,
                              input logic [31:0] i_ma, input logic m_rw, input logic m_m,
                              input logic b, input logic q, input logic y,
                              input logic [6:0] c, input logic [1:0] s, input logic e);
    vec_t v;
    v.rst = r; v.if_ir = i_if; v.ex_ir = i_ex; v.ex_rw = e_rw; v.ex_m2r = e_m;
    v.ma_ir = i_ma; v.ma_rw = m_rw; v.ma_m2r = m_m; v.br = b; v.req = q; v.rdy = y;
    v.ctl = c; v.st = s; v.err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare on the falling edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    rst = v.rst; IF_ID_IR = v.if_ir; ID_EX_IR = v.ex_ir; EX_MA_IR = v.ma_ir;
    ID_EX_RegWr = v.ex_rw; ID_EX_MemtoReg = v.ex_m2r;
    EX_MA_RegWr = v.ma_rw; EX_MA_MemtoReg = v.ma_m2r;
    ex_branch_taken = v.br; dmem_req = v.req; dmem_ready = v.rdy;
    e.ctl = v.ctl; e.st = v.st; e.err = v.err;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " ctl"}, {25'd0, PC_Wr, IF_ID_Wr, ID_EX_Wr, EX_MA_Wr, MA_WB_Wr,
                          IF_ID_Flush, ID_EX_Flush}, {25'd0, e.ctl});
      chk({tag, " state"}, {30'd0, state}, {30'd0, e.st});
      chk({tag, " mem_err"}, {31'd0, mem_err}, {31'd0, e.err});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; IF_ID_IR = NOP; ID_EX_IR = NOP; EX_MA_IR = NOP;
    ID_EX_RegWr = 0; ID_EX_MemtoReg = 0; EX_MA_RegWr = 0; EX_MA_MemtoReg = 0;
    ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a load-use stall
    step(mk(0, ADD, LW2,1,1, NOP,0,0, 0,0,0, BUB,  S_RUN, 0), "rstA0");
`ifdef HAZ_STAT_EN
    chk("rstA stall_cnt pre", {16'd0, stall_cnt}, 32'd1);
`endif
    step(mk(1, ADD, NOP,0,0, LW2,1,1, 0,0,0, RSTV, S_LU2, 0), "rstA1");
`ifdef HAZ_STAT_EN
    chk("rstA stall_cnt post", {16'd0, stall_cnt}, 32'd0);
`endif
    step(mk(0, NOP, NOP,0,0, NOP,0,0, 0,0,0, NORM, S_RUN, 0), "rstA2");

    tbl.push_back(mk(1, NOP,  NOP,0,0, NOP,0,0,   0,0,0, RSTV, S_RUN, 0)); // 0
    tbl.push_back(mk(0, ADD,  LW2,1,1, NOP,0,0,   0,0,0, BUB,  S_RUN, 0)); // 1 lu_ex
    tbl.push_back(mk(0, ADD,  NOP,0,0, LW2,1,1,   0,0,0, BUB,  S_LU2, 0)); // 2 LU2
    tbl.push_back(mk(0, ADD,  NOP,0,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 3
    tbl.push_back(mk(0, SUB,  NOP,0,0, LW5,1,1,   0,0,0, BUB,  S_RUN, 0)); // 4 lu_ma
    tbl.push_back(mk(0, SUB,  NOP,0,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 5
    tbl.push_back(mk(0, ADD0, LW0,1,1, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 6 $0
    tbl.push_back(mk(0, JMP,  LW2,1,1, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 7 j
    tbl.push_back(mk(0, JMP2, LW2,1,1, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 8 j fields
    tbl.push_back(mk(0, LUI2, LW2,1,1, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 9 lui
    tbl.push_back(mk(0, ADDI, LW2,1,1, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 10 rt unread
    tbl.push_back(mk(0, SW2,  LW2,1,1, NOP,0,0,   0,0,0, BUB,  S_RUN, 0)); // 11 sw rt
    tbl.push_back(mk(0, SW2,  NOP,0,0, LW2,1,1,   0,0,0, BUB,  S_LU2, 0)); // 12
    tbl.push_back(mk(0, ADD,  LW2,1,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 13 not a load
    tbl.push_back(mk(0, ADD,  LW2,1,1, NOP,0,0,   1,0,0, FLS,  S_RUN, 0)); // 14 branch wins
    tbl.push_back(mk(0, ADD,  NOP,0,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 15
    tbl.push_back(mk(0, JR31, NOP,0,0, JAL_I,1,1, 0,0,0, BUB,  S_RUN, 0)); // 16 dst 31
    tbl.push_back(mk(0, NOP,  NOP,0,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 17
    tbl.push_back(mk(0, ADD,  LW2,1,1, NOP,0,0,   0,0,0, BUB,  S_RUN, 0)); // 18
    tbl.push_back(mk(0, ADD,  NOP,0,0, LW2,1,1,   1,0,0, FLS,  S_LU2, 0)); // 19 branch in LU2
    tbl.push_back(mk(0, NOP,  NOP,0,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 20
    tbl.push_back(mk(0, ADD,  LW2,1,1, NOP,0,0,   0,0,0, BUB,  S_RUN, 0)); // 21
    tbl.push_back(mk(0, ADD,  NOP,0,0, LW2,1,1,   0,1,0, FRZ,  S_LU2, 0)); // 22 wait in LU2
    tbl.push_back(mk(0, ADD,  NOP,0,0, LW2,1,1,   0,1,0, FRZ,  S_MW,  0)); // 23
    tbl.push_back(mk(0, ADD,  NOP,0,0, LW2,1,1,   0,1,0, FRZ,  S_MW,  0)); // 24
    tbl.push_back(mk(0, ADD,  NOP,0,0, LW2,1,1,   0,1,1, BUB,  S_MW,  0)); // 25 release
    tbl.push_back(mk(0, ADD,  NOP,0,0, NOP,0,0,   0,0,0, NORM, S_RUN, 0)); // 26
    tbl.push_back(mk(0, NOP,  NOP,0,0, NOP,0,0,   0,1,1, NORM, S_RUN, 0)); // 27 req&ready

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end
`ifdef HAZ_STAT_EN
    chk("stall_cnt table", {16'd0, stall_cnt}, 32'd12);
    chk("flush_cnt table", {16'd0, flush_cnt}, 32'd2);
`endif

    // Memory timeout: five wait cycles with MEM_TIMEOUT = 4
    step(mk(0, NOP, NOP,0,0, NOP,0,0, 0,1,0, FRZ,  S_RUN, 0), "tmo0");
    for (int k = 1; k < 5; k++) begin
      step(mk(0, NOP, NOP,0,0, NOP,0,0, 0,1,0, FRZ, S_MW, (k == 4)), $sformatf("tmo%0d", k));
    end
    step(mk(0, NOP, NOP,0,0, NOP,0,0, 0,1,1, NORM, S_MW,  1), "tmo_rel");
    step(mk(0, NOP, NOP,0,0, NOP,0,0, 0,0,0, NORM, S_RUN, 1), "tmo_sticky");
    step(mk(1, NOP, NOP,0,0, NOP,0,0, 0,0,0, RSTV, S_RUN, 1), "tmo_rst");
    step(mk(0, NOP, NOP,0,0, NOP,0,0, 0,0,0, NORM, S_RUN, 0), "tmo_clr");

    chk("queue drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
